alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 100 ++++++++++
 tb/tb_alu.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 64-bit registered ALU: ADD/SUB through one ripple chain of full-adder cells,
// AND/XOR through per-bit gate arrays, with OF/SF/ZF condition codes.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module alu (
    input  logic [63:0] ALUA,
    input  logic [63:0] ALUB,
    input  logic [1:0]  ALUfun,
    output logic [63:0] valE,
    output logic [2:0]  CC,
    input  logic        clk,
    input  logic        rst
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    op_e         op;
    logic        is_sub;
    logic [63:0] b_eff;
    logic [63:0] sum;
    logic [63:0] carry;
    logic        carry_unused;
    logic [63:0] and_res;
    logic [63:0] xor_res;
    logic [63:0] result;
    logic        of_flag;
    logic        sf_flag;
    logic        zf_flag;

    assign op     = op_e'(ALUfun);
    assign is_sub = (op == OP_SUB);

    // Subtraction reuses the adder: invert B and inject the +1 as carry-in.
    assign b_eff    = is_sub ? ~ALUB : ALUB;
    assign carry[0] = is_sub;

    for (genvar i = 0; i < 64; i++) begin : g_bits
        if (i < 63) begin : g_fa
            full_adder u_fa (
                .a    (ALUA[i]),
                .b    (b_eff[i]),
                .cin  (carry[i]),
                .sum  (sum[i]),
                .cout (carry[i+1])
            );
        end else begin : g_fa_msb
            full_adder u_fa (
                .a    (ALUA[i]),
                .b    (b_eff[i]),
                .cin  (carry[i]),
                .sum  (sum[i]),
                .cout (carry_unused)
            );
        end
        assign and_res[i] = ALUA[i] & ALUB[i];
        assign xor_res[i] = ALUA[i] ^ ALUB[i];
    end

    always_comb begin
        result  = sum;
        of_flag = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                result  = sum;
                // Operands of matching sign (after B inversion) yielding a sign flip.
                of_flag = (ALUA[63] == b_eff[63]) && (sum[63] != ALUA[63]);
            end
            OP_AND: result = and_res;
            OP_XOR: result = xor_res;
            default: result = sum;
        endcase
    end

    assign sf_flag = result[63];
    assign zf_flag = (result == 64'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valE <= 64'd0;
            CC   <= 3'b000;
        end else begin
            valE <= result;
            CC   <= {zf_flag, sf_flag, of_flag};
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed and random checks of the alu against a 65-bit reference model
// through an expected-result queue.

module tb_alu;
    logic [63:0] ALUA;
    logic [63:0] ALUB;
    logic [1:0]  ALUfun;
    logic [63:0] valE;
    logic [2:0]  CC;
    logic        clk;
    logic        rst;

    int          vectors;
    int          miscompares;
    logic [66:0] sb[$];
    logic [66:0] last_exp;

    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_SUB = 2'b01;
    localparam logic [1:0] F_AND = 2'b10;
    localparam logic [1:0] F_XOR = 2'b11;

    alu dut (
        .ALUA   (ALUA),
        .ALUB   (ALUB),
        .ALUfun (ALUfun),
        .valE   (valE),
        .CC     (CC),
        .clk    (clk),
        .rst    (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overflow comes from a sign-extended 65-bit sum disagreeing in its top two bits.
    function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] f);
        logic [64:0] wide;
        logic [63:0] r;
        logic        of;
        wide = '0;
        r    = '0;
        of   = 1'b0;
        case (f)
            F_ADD: begin
                wide = {a[63], a} + {b[63], b};
                r    = wide[63:0];
                of   = wide[64] != wide[63];
            end
            F_SUB: begin
                wide = {a[63], a} - {b[63], b};
                r    = wide[63:0];
                of   = wide[64] != wide[63];
            end
            F_AND: r = a & b;
            default: r = a ^ b;
        endcase
        return {r, (r == 64'd0), r[63], of};
    endfunction

    task automatic check_output(input string tag, input logic [66:0] exp);
        vectors++;
        assert ({valE, CC} === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed valE=%h CC=%b, expected valE=%h CC=%b",
                   tag, valE, CC, exp[66:3], exp[2:0]);
        end
    endtask

    task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] f, input string tag);
        @(negedge clk);
        ALUA   = a;
        ALUB   = b;
        ALUfun = f;
        sb.push_back(model(a, b, f));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s: observed empty scoreboard, expected one entry", tag);
        end else begin
            last_exp = sb.pop_front();
            check_output(tag, last_exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_exp    = '0;
        ALUA        = '0;
        ALUB        = '0;
        ALUfun      = F_ADD;
        rst         = 1'b0;

        // Power-up reset, applied away from any clock edge.
        #1 rst = 1'b1;
        #2 check_output("reset_async", 67'd0);
        @(posedge clk);
        #1 check_output("reset_held", 67'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic arithmetic and logic, back to back.
        apply_stimulus(64'd45, 64'd38, F_ADD, "add_45_38");
        check_output("add_45_38_const", {64'd83, 3'b000});
        apply_stimulus(64'd45, 64'd38, F_SUB, "sub_45_38");
        check_output("sub_45_38_const", {64'd7, 3'b000});
        apply_stimulus(64'd45, 64'd38, F_AND, "and_45_38");
        check_output("and_45_38_const", {64'd36, 3'b000});
        apply_stimulus(64'd45, 64'd38, F_XOR, "xor_45_38");
        check_output("xor_45_38_const", {64'd11, 3'b000});

        // Sign flag.
        apply_stimulus(-64'd45, 64'd38, F_ADD, "add_m45_38");
        check_output("add_m45_38_const", {-64'd7, 3'b010});
        apply_stimulus(-64'd45, 64'd38, F_SUB, "sub_m45_38");
        check_output("sub_m45_38_const", {-64'd83, 3'b010});
        apply_stimulus(64'd45, -64'd38, F_SUB, "sub_45_m38");
        check_output("sub_45_m38_const", {64'd83, 3'b000});

        // Overflow boundaries.
        apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, F_ADD, "ovf_add");
        check_output("ovf_add_const", {64'h8000_0000_0000_0000, 3'b011});
        apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, -64'd1, F_SUB, "ovf_sub");
        check_output("ovf_sub_const", {64'h8000_0000_0000_0000, 3'b011});
        apply_stimulus(64'h8000_0000_0000_0000, 64'd1, F_SUB, "ovf_min_minus1");
        check_output("ovf_min_minus1_const", {64'h7FFF_FFFF_FFFF_FFFF, 3'b001});

        // Zero flag.
        apply_stimulus(64'd0, 64'd0, F_ADD, "zero_add");
        check_output("zero_add_const", {64'd0, 3'b100});
        apply_stimulus(64'd45, 64'd45, F_XOR, "zero_xor");
        check_output("zero_xor_const", {64'd0, 3'b100});
        apply_stimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, F_SUB, "zero_min_sub");
        check_output("zero_min_sub_const", {64'd0, 3'b100});

        // Outputs must not follow inputs between edges.
        apply_stimulus(64'd45, 64'd38, F_ADD, "hold_setup");
        ALUA   = 64'h1234_5678_9ABC_DEF0;
        ALUB   = 64'h0F0F_0F0F_0F0F_0F0F;
        ALUfun = F_XOR;
        #2 check_output("hold_between_edges", last_exp);
        check_output("hold_between_edges_const", {64'd83, 3'b000});

        // Mid-stream reset with output at 83: clears at once and discards the next op.
        @(negedge clk);
        ALUA   = 64'd100;
        ALUB   = 64'd23;
        ALUfun = F_ADD;
        #2 rst = 1'b1;
        #1 check_output("reset_midstream", 67'd0);
        @(posedge clk);
        #1 check_output("reset_discard", 67'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(64'd100, 64'd23, F_SUB, "after_reset");
        check_output("after_reset_const", {64'd77, 3'b000});

        // Random back-to-back traffic, biased toward sign boundaries.
        for (int i = 0; i < 60; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 0) ra[62:0] = {63{ra[63] ^ 1'b1}};
            if (i % 5 == 0) rb = ra;
            apply_stimulus(ra, rb, 2'($urandom_range(0, 3)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
